// File: rtl/wb_uart_slave.sv
// Wishbone pipelined UART slave: SETUP/STATUS/RXDATA/TXDATA registers, TX/RX byte FIFOs, 8N1 serdes.
// Ack one cycle after stb, never stalls; full TX FIFO drops writes (sticky), full RX FIFO drops bytes (overrun).

module wb_uart_fifo #(
  parameter int LGFLEN = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_vld,
  input  logic [7:0]      push_dat,
  input  logic            pop_vld,
  output logic [7:0]      head_dat,
  output logic [LGFLEN:0] cnt,
  output logic            empty,
  output logic            full
);
  localparam logic [LGFLEN:0] DEPTH = (LGFLEN+1)'(2**LGFLEN);

  logic [7:0]        mem [2**LGFLEN];
  logic [LGFLEN-1:0] wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == DEPTH);
  assign do_pop   = pop_vld && !empty;
  // a pop frees the slot the push lands in, so push+pop at full is legal
  assign do_push  = push_vld && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (LGFLEN+1)'(do_push) - (LGFLEN+1)'(do_pop);
    end
  end
endmodule

module wb_uart_slave #(
  parameter int AW        = 2,
  parameter int DW        = 32,
  parameter int LGFLEN    = 4,
  parameter int INIT_BAUD = 868
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [AW-1:0]   wb_addr_i,
  input  logic [DW-1:0]   wb_data_i,
  input  logic [DW/8-1:0] wb_sel_i,
  output logic            wb_stall_o,
  output logic            wb_ack_o,
  output logic [DW-1:0]   wb_data_o,
  input  logic            uart_rx_i,
  output logic            uart_tx_o
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  localparam logic [LGFLEN:0] DEPTH = (LGFLEN+1)'(2**LGFLEN);

  logic            req, rd_req, wr_req, rx_rd, tx_rd;
  logic [23:0]     setup, setup_wr;
  logic [DW-1:0]   rd_dat;
  logic            tx_push, tx_pop, tx_busy, tx_ovf;
  logic            rx_push, rx_ferr_set, rx_ovr, rx_ferr;
  logic [7:0]      txf_head, rxf_head;
  logic [LGFLEN:0] txf_cnt, rxf_cnt;
  logic            txf_empty, txf_full, rxf_empty, rxf_full;
  logic            unused_ok;

  assign req        = wb_cyc_i && wb_stb_i;
  assign rd_req     = req && !wb_we_i;
  assign wr_req     = req && wb_we_i;
  assign rx_rd      = rd_req && (wb_addr_i == AW'(2));
  assign tx_rd      = rd_req && (wb_addr_i == AW'(3));
  assign tx_push    = wr_req && (wb_addr_i == AW'(3)) && wb_sel_i[0];
  assign wb_stall_o = 1'b0;
  assign unused_ok  = &{1'b0, wb_sel_i[DW/8-1:3], wb_data_i[DW-1:24]};

  always_comb begin
    setup_wr = setup;
    for (int i = 0; i < 3; i++)
      if (wb_sel_i[i]) setup_wr[8*i +: 8] = wb_data_i[8*i +: 8];
  end

  always_comb begin
    rd_dat = '0;
    case (wb_addr_i)
      AW'(0): rd_dat[23:0] = setup;
      AW'(1): begin
        rd_dat[LGFLEN:0]        = rxf_cnt;
        rd_dat[8]               = rxf_empty;
        rd_dat[9]               = txf_full;
        rd_dat[10]              = tx_busy;
        rd_dat[16+LGFLEN:16]    = DEPTH - txf_cnt;
      end
      AW'(2): begin
        rd_dat[7:0] = rxf_empty ? 8'h00 : rxf_head;
        rd_dat[8]   = rxf_empty;
        rd_dat[9]   = rx_ovr;
        rd_dat[10]  = rx_ferr;
      end
      default: begin
        rd_dat[9]  = txf_full;
        rd_dat[10] = tx_busy;
        rd_dat[11] = tx_ovf;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_ack_o  <= 1'b0;
      wb_data_o <= '0;
      setup     <= 24'(INIT_BAUD);
      tx_ovf    <= 1'b0;
      rx_ovr    <= 1'b0;
      rx_ferr   <= 1'b0;
    end else begin
      wb_ack_o <= req;
      if (rd_req) wb_data_o <= rd_dat;
      if (wr_req && wb_addr_i == AW'(0)) setup <= (setup_wr < 24'd4) ? 24'd4 : setup_wr;
      // sticky flags: a set in the same cycle as the clearing read wins
      if (tx_push && txf_full && !tx_pop) tx_ovf <= 1'b1;
      else if (tx_rd)                     tx_ovf <= 1'b0;
      if (rx_push && rxf_full && !rx_rd)  rx_ovr <= 1'b1;
      else if (rx_rd)                     rx_ovr <= 1'b0;
      if (rx_ferr_set)                    rx_ferr <= 1'b1;
      else if (rx_rd)                     rx_ferr <= 1'b0;
    end
  end

  // ---------------- transmitter ----------------
  state_t      tx_state, tx_state_nxt;
  logic [23:0] tx_div, tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;
  logic        tx_tick;

  wb_uart_fifo #(.LGFLEN(LGFLEN)) u_txf (
    .clk_i(clk_i), .rst_i(rst_i), .push_vld(tx_push), .push_dat(wb_data_i[7:0]),
    .pop_vld(tx_pop), .head_dat(txf_head), .cnt(txf_cnt), .empty(txf_empty), .full(txf_full)
  );

  assign tx_tick = (tx_cnt == tx_div - 24'd1);
  assign tx_busy = !txf_empty || (tx_state != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) tx_state <= S_IDLE;
    else       tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_pop       = 1'b0;
    case (tx_state)
      S_IDLE:  if (!txf_empty) begin tx_pop = 1'b1; tx_state_nxt = S_START; end
      S_START: if (tx_tick) tx_state_nxt = S_DATA;
      S_DATA:  if (tx_tick && tx_bit == 3'd7) tx_state_nxt = S_STOP;
      S_STOP:  if (tx_tick) begin
        // chain straight into the next start bit so queued frames have no idle gap
        if (!txf_empty) begin tx_pop = 1'b1; tx_state_nxt = S_START; end
        else tx_state_nxt = S_IDLE;
      end
      default: tx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      uart_tx_o <= 1'b1;
      tx_div    <= 24'(INIT_BAUD);
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_sh     <= '0;
    end else if (tx_pop) begin
      uart_tx_o <= 1'b0;
      tx_div    <= setup;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_sh     <= txf_head;
    end else if (tx_state != S_IDLE) begin
      if (tx_tick) begin
        tx_cnt <= '0;
        if (tx_state == S_START) uart_tx_o <= tx_sh[0];
        else if (tx_state == S_DATA) begin
          tx_sh     <= tx_sh >> 1;
          tx_bit    <= tx_bit + 1'b1;
          uart_tx_o <= (tx_bit == 3'd7) ? 1'b1 : tx_sh[1];
        end else uart_tx_o <= 1'b1;
      end else tx_cnt <= tx_cnt + 24'd1;
    end
  end

  // ---------------- receiver ----------------
  state_t      rx_state, rx_state_nxt;
  logic        rx_meta, rx_s, rx_d, rx_fall, rx_tick;
  logic [23:0] rx_div, rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;

  wb_uart_fifo #(.LGFLEN(LGFLEN)) u_rxf (
    .clk_i(clk_i), .rst_i(rst_i), .push_vld(rx_push), .push_dat(rx_sh),
    .pop_vld(rx_rd), .head_dat(rxf_head), .cnt(rxf_cnt), .empty(rxf_empty), .full(rxf_full)
  );

  assign rx_fall = rx_d && !rx_s;
  // start bit is checked half a bit in, which puts every later sample at mid-bit
  assign rx_tick = (rx_state == S_START) ? (rx_cnt == {1'b0, rx_div[23:1]} - 24'd1)
                                         : (rx_cnt == rx_div - 24'd1);

  always_ff @(posedge clk_i) begin
    if (rst_i) rx_state <= S_IDLE;
    else       rx_state <= rx_state_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_push      = 1'b0;
    rx_ferr_set  = 1'b0;
    case (rx_state)
      S_IDLE:  if (rx_fall) rx_state_nxt = S_START;
      S_START: if (rx_tick) rx_state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_nxt = S_STOP;
      S_STOP:  if (rx_tick) begin
        rx_state_nxt = S_IDLE;
        rx_push      = rx_s;
        rx_ferr_set  = !rx_s;
      end
      default: rx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
      rx_div  <= 24'(INIT_BAUD);
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
    end else begin
      rx_meta <= uart_rx_i;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
      if (rx_state == S_IDLE) begin
        rx_cnt <= '0;
        rx_bit <= '0;
        if (rx_fall) rx_div <= setup;
      end else if (rx_tick) begin
        rx_cnt <= '0;
        if (rx_state == S_DATA) begin
          rx_sh  <= {rx_s, rx_sh[7:1]};
          rx_bit <= rx_bit + 1'b1;
        end
      end else rx_cnt <= rx_cnt + 24'd1;
    end
  end
endmodule
